// File: rtl/pineball_vga_pkg.sv
// Shared timing defaults, colour width and total-length helper for the ball renderer.
`default_nettype none

package pineball_vga_pkg;

  localparam int H_DISP_DEF  = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int V_DISP_DEF  = 480;
  localparam int V_FRONT_DEF = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;

  localparam int COLOR_W = 12;
  typedef logic [COLOR_W-1:0] rgb_t;

  function automatic int total4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  localparam int H_TOTAL_DEF = total4(H_DISP_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = total4(V_DISP_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

`default_nettype wire

// File: rtl/pineball_vga_render_if.sv
// Ball position in, video timing and pixel colour out.
`default_nettype none

interface pineball_vga_render_if #(
  parameter int POS_BITS = 10
);
  logic [POS_BITS-1:0]                    pos_x;
  logic [POS_BITS-1:0]                    pos_y;
  logic                                   frame_tick;
  logic                                   hsync;
  logic                                   vsync;
  logic                                   de;
  logic [pineball_vga_pkg::COLOR_W-1:0]   rgb;

  modport master (
    input  pos_x, pos_y,
    output frame_tick, hsync, vsync, de, rgb
  );

  modport slave (
    output pos_x, pos_y,
    input  frame_tick, hsync, vsync, de, rgb
  );
endinterface

`default_nettype wire

// File: rtl/pineball_vga_timing.sv
// Free-running horizontal/vertical raster counters.
`default_nettype none

module pineball_vga_timing #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_W     = 10,
  parameter int V_W     = 10
) (
  input  logic           clk,
  input  logic           rst,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt
);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt = h_cnt_q;
  assign v_cnt = v_cnt_q;

endmodule

`default_nettype wire

// File: rtl/pineball_vga_render.sv
// VGA sync generation plus a square ball overlay; all outputs registered one cycle after the counters.
`default_nettype none

module pineball_vga_render
  import pineball_vga_pkg::*;
#(
  parameter int   H_DISP     = H_DISP_DEF,
  parameter int   H_FRONT    = H_FRONT_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BACK     = H_BACK_DEF,
  parameter int   V_DISP     = V_DISP_DEF,
  parameter int   V_FRONT    = V_FRONT_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BACK     = V_BACK_DEF,
  parameter int   POS_BITS   = 10,
  parameter int   SIZE       = 5,
  parameter rgb_t BALL_COLOR = 12'hFFF,
  parameter rgb_t BG_COLOR   = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst,
  pineball_vga_render_if.master vif
);

  localparam int H_TOTAL = total4(H_DISP, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total4(V_DISP, V_FRONT, V_SYNC, V_BACK);
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  // Compare width covers both counters and position+SIZE without wrap-around.
  localparam int CW_A    = (POS_BITS + 1 > H_W) ? POS_BITS + 1 : H_W;
  localparam int CW      = (CW_A > V_W) ? CW_A : V_W;

  localparam logic [H_W-1:0] H_VIS    = H_W'(H_DISP);
  localparam logic [H_W-1:0] HS_START = H_W'(H_DISP + H_FRONT);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_DISP + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_VIS    = V_W'(V_DISP);
  localparam logic [V_W-1:0] VS_START = V_W'(V_DISP + V_FRONT);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_DISP + V_FRONT + V_SYNC);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  pineball_vga_timing #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_W     (H_W),
    .V_W     (V_W)
  ) u_timing (
    .clk   (clk),
    .rst   (rst),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt)
  );

  logic [POS_BITS-1:0] shadow_x_q, shadow_x_d;
  logic [POS_BITS-1:0] shadow_y_q, shadow_y_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                de_q, de_d;
  logic                tick_q, tick_d;
  rgb_t                rgb_q, rgb_d;
  logic [CW-1:0]       x_e, y_e, sx_e, sy_e;
  logic                in_ball;

  always_comb begin
    x_e  = CW'(h_cnt);
    y_e  = CW'(v_cnt);
    sx_e = CW'(shadow_x_q);
    sy_e = CW'(shadow_y_q);
    in_ball = (x_e >= sx_e) && (x_e < sx_e + CW'(SIZE)) &&
              (y_e >= sy_e) && (y_e < sy_e + CW'(SIZE));

    tick_d  = (h_cnt == '0) && (v_cnt == V_VIS);
    hsync_d = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vsync_d = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    de_d    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    rgb_d   = '0;
    if (de_d) rgb_d = in_ball ? BALL_COLOR : BG_COLOR;

    // Position is sampled only at the start of vertical blanking so a frame never tears.
    shadow_x_d = tick_d ? vif.pos_x : shadow_x_q;
    shadow_y_d = tick_d ? vif.pos_y : shadow_y_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_x_q <= '0;
      shadow_y_q <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      de_q       <= 1'b0;
      tick_q     <= 1'b0;
      rgb_q      <= '0;
    end else begin
      shadow_x_q <= shadow_x_d;
      shadow_y_q <= shadow_y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      de_q       <= de_d;
      tick_q     <= tick_d;
      rgb_q      <= rgb_d;
    end
  end

  assign vif.hsync      = hsync_q;
  assign vif.vsync      = vsync_q;
  assign vif.de         = de_q;
  assign vif.frame_tick = tick_q;
  assign vif.rgb        = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_pineball_vga_render.sv
// Self-checking bench for pineball_vga_render on a shrunken raster, against a raster-position model.
`default_nettype none

module tb_pineball_vga_render;
  import pineball_vga_pkg::*;

  localparam int   H_DISP = 40, H_FRONT = 4, H_SYNC = 8, H_BACK = 4;
  localparam int   V_DISP = 30, V_FRONT = 2, V_SYNC = 2, V_BACK = 3;
  localparam int   H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam int   FRAME = H_TOTAL * V_TOTAL;
  localparam int   POS_BITS = 10, SIZE = 5;
  localparam rgb_t BALL_COLOR = 12'hF80, BG_COLOR = 12'h00F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pineball_vga_render_if #(.POS_BITS(POS_BITS)) vif ();

  pineball_vga_render #(
    .H_DISP(H_DISP), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISP(V_DISP), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .POS_BITS(POS_BITS), .SIZE(SIZE), .BALL_COLOR(BALL_COLOR), .BG_COLOR(BG_COLOR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  int checks = 0, passed = 0;
  // Model: raster position processed at the next edge and the latched ball position.
  int mh, mv, msx, msy;
  int hs_lo, vs_lo, de_hi, ball, ticks, tick_bad, mism, edge_px, minx, maxx, miny, maxy;

  task automatic clear_stats();
    hs_lo = 0; vs_lo = 0; de_hi = 0; ball = 0; ticks = 0; tick_bad = 0; mism = 0; edge_px = 0;
    minx = 99999; maxx = -1; miny = 99999; maxy = -1;
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; msx = 0; msy = 0;
  endtask

  task automatic step();
    int px = int'(vif.pos_x);
    int py = int'(vif.pos_y);
    int eh = mh;
    int ev = mv;
    logic ede, ehs, evs, etk, eball;
    rgb_t ergb;
    ede   = (eh < H_DISP) && (ev < V_DISP);
    ehs   = !(eh >= H_DISP + H_FRONT && eh < H_DISP + H_FRONT + H_SYNC);
    evs   = !(ev >= V_DISP + V_FRONT && ev < V_DISP + V_FRONT + V_SYNC);
    etk   = (eh == 0) && (ev == V_DISP);
    eball = ede && eh >= msx && eh < msx + SIZE && ev >= msy && ev < msy + SIZE;
    ergb  = !ede ? 12'h000 : (eball ? BALL_COLOR : BG_COLOR);
    @(posedge clk);
    #1;
    if (etk) begin msx = px; msy = py; end
    mh = mh + 1;
    if (mh == H_TOTAL) begin mh = 0; mv = (mv + 1) % V_TOTAL; end
    if (!vif.hsync) hs_lo++;
    if (!vif.vsync) vs_lo++;
    if (vif.de) de_hi++;
    if (vif.frame_tick) begin
      ticks++;
      if (eh != 0 || ev != V_DISP || vif.de) tick_bad++;
    end
    if (vif.de && vif.rgb === BALL_COLOR) begin
      ball++;
      if (eh < minx) minx = eh;
      if (eh > maxx) maxx = eh;
      if (ev < miny) miny = ev;
      if (ev > maxy) maxy = ev;
      if (eh == 0 || ev == 0) edge_px++;
    end
    if ({vif.hsync, vif.vsync, vif.de, vif.frame_tick, vif.rgb} !== {ehs, evs, ede, etk, ergb}) mism++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int span(input int s, input int lim);
    int e;
    if (s >= lim) return 0;
    e = (s + SIZE > lim) ? lim : s + SIZE;
    return e - s;
  endfunction

  task automatic test_reset();
    int n;
    vif.pos_x = '0; vif.pos_y = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vif.hsync, vif.vsync, vif.de, vif.frame_tick, vif.rgb} !== {4'b1100, 12'h000})
      $display("FAIL reset_outputs: got hs=%b vs=%b de=%b tick=%b rgb=%h, expected 1 1 0 0 000",
               vif.hsync, vif.vsync, vif.de, vif.frame_tick, vif.rgb);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_stats();
    n = 0;
    do begin step(); n++; end while (vif.hsync && n < 2 * H_TOTAL);
    checks++;
    if (n != H_DISP + H_FRONT + 1) $display("FAIL first_hsync: got %0d cycles, expected %0d", n, H_DISP + H_FRONT + 1);
    else passed++;
    run(FRAME - n);
    checks++;
    if (mism != 0) $display("FAIL reset_frame_model: got %0d mismatching cycles, expected 0", mism);
    else passed++;
  endtask

  task automatic test_timing();
    vif.pos_x = 10'd10; vif.pos_y = 10'd12;
    clear_stats();
    run(H_TOTAL);
    checks++;
    if (hs_lo != H_SYNC) $display("FAIL line_hsync_low: got %0d, expected %0d", hs_lo, H_SYNC);
    else passed++;
    checks++;
    if (de_hi != H_DISP) $display("FAIL line_de_high: got %0d, expected %0d", de_hi, H_DISP);
    else passed++;
    run(FRAME - H_TOTAL);
    checks++;
    if (hs_lo != H_SYNC * V_TOTAL) $display("FAIL frame_hsync_low: got %0d, expected %0d", hs_lo, H_SYNC * V_TOTAL);
    else passed++;
    checks++;
    if (vs_lo != V_SYNC * H_TOTAL) $display("FAIL frame_vsync_low: got %0d, expected %0d", vs_lo, V_SYNC * H_TOTAL);
    else passed++;
    checks++;
    if (de_hi != H_DISP * V_DISP) $display("FAIL frame_de_high: got %0d, expected %0d", de_hi, H_DISP * V_DISP);
    else passed++;
    checks++;
    if (mism != 0) $display("FAIL timing_model: got %0d mismatching cycles, expected 0", mism);
    else passed++;
  endtask

  task automatic test_ball();
    clear_stats();
    run(FRAME);
    checks++;
    if (ball != SIZE * SIZE) $display("FAIL ball_count: got %0d, expected %0d", ball, SIZE * SIZE);
    else passed++;
    checks++;
    if (minx != 10 || maxx != 14 || miny != 12 || maxy != 16)
      $display("FAIL ball_box: got x %0d..%0d y %0d..%0d, expected x 10..14 y 12..16", minx, maxx, miny, maxy);
    else passed++;
    checks++;
    if (mism != 0) $display("FAIL ball_model: got %0d mismatching cycles, expected 0", mism);
    else passed++;
  endtask

  task automatic test_tearing();
    clear_stats();
    run(15 * H_TOTAL);
    vif.pos_x = 10'd20; vif.pos_y = 10'd20;
    run(FRAME - 15 * H_TOTAL);
    checks++;
    if (ball != 25 || minx != 10 || miny != 12)
      $display("FAIL tearing_old_pos: got %0d px at (%0d,%0d), expected 25 px at (10,12)", ball, minx, miny);
    else passed++;
    clear_stats();
    vif.pos_x = 10'd37; vif.pos_y = 10'd28;
    run(FRAME);
    checks++;
    if (ball != 25 || minx != 20 || miny != 20 || maxx != 24 || maxy != 24)
      $display("FAIL tearing_new_pos: got %0d px at x %0d..%0d y %0d..%0d, expected 25 px at 20..24", ball, minx, maxx, miny, maxy);
    else passed++;
    checks++;
    if (mism != 0) $display("FAIL tearing_model: got %0d mismatching cycles, expected 0", mism);
    else passed++;
  endtask

  task automatic test_clipping();
    clear_stats();
    vif.pos_x = 10'd1022; vif.pos_y = 10'd1020;
    run(FRAME);
    checks++;
    if (ball != 6) $display("FAIL clip_count: got %0d, expected 6", ball);
    else passed++;
    checks++;
    if (minx != 37 || maxx != 39 || miny != 28 || maxy != 29)
      $display("FAIL clip_box: got x %0d..%0d y %0d..%0d, expected x 37..39 y 28..29", minx, maxx, miny, maxy);
    else passed++;
    checks++;
    if (edge_px != 0) $display("FAIL clip_wrap_edge: got %0d px at col/row 0, expected 0", edge_px);
    else passed++;
  endtask

  task automatic test_wrap();
    clear_stats();
    vif.pos_x = 10'd30; vif.pos_y = 10'd5;
    run(FRAME);
    checks++;
    if (ball != 0 || edge_px != 0) $display("FAIL wrap_clip: got %0d ball px (%0d at col/row 0), expected 0", ball, edge_px);
    else passed++;
    checks++;
    if (mism != 0) $display("FAIL wrap_model: got %0d mismatching cycles, expected 0", mism);
    else passed++;
  endtask

  task automatic test_frame_tick();
    clear_stats();
    run(FRAME);
    checks++;
    if (ticks != 1) $display("FAIL tick_count: got %0d pulses, expected 1", ticks);
    else passed++;
    checks++;
    if (tick_bad != 0) $display("FAIL tick_position: got %0d misplaced pulses, expected 0", tick_bad);
    else passed++;
    checks++;
    if (ball != 25 || minx != 30 || miny != 5) $display("FAIL tick_ball: got %0d px at (%0d,%0d), expected 25 at (30,5)", ball, minx, miny);
    else passed++;
  endtask

  task automatic test_random();
    int exp_ball;
    for (int f = 0; f < 6; f++) begin
      clear_stats();
      exp_ball = span(msx, H_DISP) * span(msy, V_DISP);
      for (int c = 0; c < FRAME; c++) begin
        if ($urandom_range(399) == 0) begin
          if ($urandom_range(7) == 0) begin
            vif.pos_x = POS_BITS'($urandom_range(1023));
            vif.pos_y = POS_BITS'($urandom_range(1023));
          end else begin
            vif.pos_x = POS_BITS'($urandom_range(H_DISP + 2));
            vif.pos_y = POS_BITS'($urandom_range(V_DISP + 2));
          end
        end
        step();
      end
      checks++;
      if (ball != exp_ball || mism != 0 || ticks != 1)
        $display("FAIL random_frame%0d: got ball=%0d mism=%0d ticks=%0d, expected ball=%0d mism=0 ticks=1",
                 f, ball, mism, ticks, exp_ball);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!(vif.de && mv > 3) && n < FRAME) begin step(); n++; end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({vif.hsync, vif.vsync, vif.de, vif.frame_tick, vif.rgb} !== {4'b1100, 12'h000})
      $display("FAIL midreset_async: got hs=%b vs=%b de=%b tick=%b rgb=%h, expected 1 1 0 0 000",
               vif.hsync, vif.vsync, vif.de, vif.frame_tick, vif.rgb);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vif.hsync, vif.vsync, vif.de, vif.frame_tick, vif.rgb} !== {4'b1100, 12'h000})
      $display("FAIL midreset_held: got hs=%b vs=%b de=%b tick=%b rgb=%h, expected 1 1 0 0 000",
               vif.hsync, vif.vsync, vif.de, vif.frame_tick, vif.rgb);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_stats();
    vif.pos_x = 10'd7; vif.pos_y = 10'd9;
    n = 0;
    do begin step(); n++; end while (vif.hsync && n < 2 * H_TOTAL);
    checks++;
    if (n != H_DISP + H_FRONT + 1) $display("FAIL midreset_first_hsync: got %0d, expected %0d", n, H_DISP + H_FRONT + 1);
    else passed++;
    run(FRAME - n);
    checks++;
    if (ball != 25 || minx != 0 || miny != 0) $display("FAIL midreset_shadow: got %0d px at (%0d,%0d), expected 25 at (0,0)", ball, minx, miny);
    else passed++;
    checks++;
    if (mism != 0) $display("FAIL midreset_model: got %0d mismatching cycles, expected 0", mism);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_ball();
    test_tearing();
    test_clipping();
    test_wrap();
    test_frame_tick();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d passed %0d", checks, passed);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
